hqa_col_metric: RTL and testbench
=================================

// Module: hqa_col_metric
// PURPOSE
//  Consumes the two complex 4-element columns produced by the HqA2 column stage (packed Q8.8).
//  Computes, at full precision, the squared norms of both columns and the cross-correlation col0^H*col1.
//  The SOML metric stage uses these terms as the Gram-matrix entries.
//  Uses one shared element-serial MAC datapath: four accumulate cycles per column pair, valid/ready on both sides.
// PARAMETERS
//  DW      16   element width, signed, Q8.8 (FRAC=8)
//  NE      4    elements per column; fixed at 4, the packed width is NE*DW=64
//  ACC_W   36   accumulator/output width, signed Q16.16; must be >= 2*DW+3
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      column pair on col*_r/i is valid
//  in_ready   out  1      block can accept a column pair (high only in IDLE)
//  col0_r     in   64     col0 real part; element k at [63-16k -: 16]
//  col0_i     in   64     col0 imaginary part, same packing
//  col1_r     in   64     col1 real part, same packing
//  col1_i     in   64     col1 imaginary part, same packing
//  norm0      out  ACC_W  sum_k r0k^2 + i0k^2
//  norm1      out  ACC_W  sum_k r1k^2 + i1k^2
//  corr_r     out  ACC_W  Re(col0^H col1) = sum_k r0k*r1k + i0k*i1k
//  corr_i     out  ACC_W  Im(col0^H col1) = sum_k r0k*i1k - i0k*r1k
//  out_valid  out  1      results valid; held until out_ready
//  out_ready  in   1      downstream accepts results
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; norm0/norm1/corr_r/corr_i=0; element index k=0.
//  FSM IDLE -> ACC -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid:
//    - capture all four column words into internal registers;
//    - clear all four accumulators and set k=0;
//    - go to ACC.
//   ACC: in_ready=0. Each cycle:
//    - add element k's terms to all four accumulators;
//    - increment k.
//    After the k=3 accumulate, register the outputs, set out_valid=1, go to DONE.
//   DONE: out_valid=1 and outputs frozen until a cycle with out_ready=1. On that edge: out_valid=0, go to IDLE.
//  Latency: accept edge E -> out_valid=1 after edge E+4. Throughput: one pair per >=6 cycles.
//  Arithmetic:
//   - full-precision signed DW x DW products (2*DW bits, Q16.16);
//   - sign-extend to ACC_W before add;
//   - no rounding, truncation or saturation;
//   - 2^33 is the worst-case magnitude, so no overflow is possible for ACC_W >= 35.
//  Input words are sampled only on the accept edge; changes afterwards are ignored.
//  in_valid while ACC or DONE: not accepted; the upstream producer must hold it.
//  in_valid and out_ready both high in DONE: only the result handshake completes. The next pair is accepted
//   in IDLE one cycle later.
//  Outputs are registered. They change only on the ACC->DONE edge or on reset, and are not cleared on leaving DONE.
//  rst mid-ACC or mid-DONE: the operation is discarded, everything returns to reset values, and no out_valid pulse occurs.
// TESTING
//  1) col0 = four elements 1.0 (0x0100), imag 0; col1 = col0.
//     -> norm0=norm1=corr_r=0x40000 (4.0), corr_i=0; out_valid exactly 4 cycles after accept.
//  2) col0_r = 0x0100_0000_0000_0000, col1_i = 0x0100_0000_0000_0000, rest 0.
//     -> norm0=norm1=0x10000, corr_r=0, corr_i=+0x10000.
//  3) All eight words = 0x8000 in every element.
//     -> norm0=norm1=0x2_0000_0000, corr_r=0x2_0000_0000, corr_i=0 (no overflow, ACC_W=36).
//  4) Hold out_ready=0 for 10 cycles after out_valid while driving new inputs with in_valid=1.
//     -> outputs stable, in_ready=0; release out_ready -> next pair accepted one cycle after leaving DONE.
//  5) Pulse rst two cycles into ACC, then re-issue test 1.
//     -> no out_valid for the aborted op; the new result equals test 1 exactly.
//  6) Random Q8.8 columns, 1000 back-to-back transactions with random out_ready.
//     -> every result bit-exact against a reference model, no lost or duplicated results.

Source files
------------

// File: rtl/hqa_col_metric.sv
// hqa_col_metric: element-serial Gram terms (|col0|^2, |col1|^2, col0^H*col1) of two complex 4-element Q8.8 columns
//   clk, rst (sync, active-high)
//   in_valid/in_ready + col0_r/col0_i/col1_r/col1_i : column pair in, element k at [63-16k -: 16]
//   norm0/norm1/corr_r/corr_i (signed Q16.16) + out_valid/out_ready : results out, held until taken
module hqa_col_metric #(
  parameter int DW = 16,
  parameter int NE = 4,
  parameter int ACC_W = 36
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NE*DW-1:0]        col0_r,
  input  logic [NE*DW-1:0]        col0_i,
  input  logic [NE*DW-1:0]        col1_r,
  input  logic [NE*DW-1:0]        col1_i,
  output logic signed [ACC_W-1:0] norm0,
  output logic signed [ACC_W-1:0] norm1,
  output logic signed [ACC_W-1:0] corr_r,
  output logic signed [ACC_W-1:0] corr_i,
  output logic                    out_valid,
  input  logic                    out_ready
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state, state_nx;
  logic [NE*DW-1:0] r0w, i0w, r1w, i1w;
  logic [1:0] k;
  logic signed [DW-1:0] e_r0 [NE];
  logic signed [DW-1:0] e_i0 [NE];
  logic signed [DW-1:0] e_r1 [NE];
  logic signed [DW-1:0] e_i1 [NE];
  logic signed [DW-1:0] r0, i0, r1, i1;
  logic signed [2*DW-1:0] p_r0r0, p_i0i0, p_r1r1, p_i1i1, p_r0r1, p_i0i1, p_r0i1, p_i0r1;
  logic signed [ACC_W-1:0] a_n0, a_n1, a_cr, a_ci, s_n0, s_n1, s_cr, s_ci;
  for (genvar g = 0; g < NE; g++) begin : g_unpack
    assign e_r0[g] = r0w[(NE-1-g)*DW +: DW];
    assign e_i0[g] = i0w[(NE-1-g)*DW +: DW];
    assign e_r1[g] = r1w[(NE-1-g)*DW +: DW];
    assign e_i1[g] = i1w[(NE-1-g)*DW +: DW];
  end
  assign r0 = e_r0[k];
  assign i0 = e_i0[k];
  assign r1 = e_r1[k];
  assign i1 = e_i1[k];
  assign p_r0r0 = (2*DW)'(r0) * (2*DW)'(r0);
  assign p_i0i0 = (2*DW)'(i0) * (2*DW)'(i0);
  assign p_r1r1 = (2*DW)'(r1) * (2*DW)'(r1);
  assign p_i1i1 = (2*DW)'(i1) * (2*DW)'(i1);
  assign p_r0r1 = (2*DW)'(r0) * (2*DW)'(r1);
  assign p_i0i1 = (2*DW)'(i0) * (2*DW)'(i1);
  assign p_r0i1 = (2*DW)'(r0) * (2*DW)'(i1);
  assign p_i0r1 = (2*DW)'(i0) * (2*DW)'(r1);
  assign s_n0 = a_n0 + ACC_W'(p_r0r0) + ACC_W'(p_i0i0);
  assign s_n1 = a_n1 + ACC_W'(p_r1r1) + ACC_W'(p_i1i1);
  assign s_cr = a_cr + ACC_W'(p_r0r1) + ACC_W'(p_i0i1);
  assign s_ci = a_ci + ACC_W'(p_r0i1) - ACC_W'(p_i0r1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    state_nx = (state == IDLE) ? (in_valid ? ACC : IDLE) :
               (state == ACC)  ? (k == 2'd3 ? DONE : ACC) :
               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      {r0w, i0w, r1w, i1w} <= '0;
      {a_n0, a_n1, a_cr, a_ci} <= '0;
      {norm0, norm1, corr_r, corr_i} <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        {r0w, i0w, r1w, i1w} <= {col0_r, col0_i, col1_r, col1_i};
        {a_n0, a_n1, a_cr, a_ci} <= '0;
        k <= '0;
      end else if (state == ACC) begin
        {a_n0, a_n1, a_cr, a_ci} <= {s_n0, s_n1, s_cr, s_ci};
        k <= k + 2'd1;
        if (k == 2'd3) {norm0, norm1, corr_r, corr_i} <= {s_n0, s_n1, s_cr, s_ci};
      end
    end
  end
endmodule

// File: tb/tb_hqa_col_metric.sv
// tb_hqa_col_metric: randomized + directed checking of hqa_col_metric against a behavioural Gram-term model
module tb_hqa_col_metric;
  typedef struct packed {
    logic [35:0] n0;
    logic [35:0] n1;
    logic [35:0] cr;
    logic [35:0] ci;
  } res_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [63:0] c0r = '0, c0i = '0, c1r = '0, c1i = '0;
  logic in_ready, out_valid;
  logic signed [35:0] norm0, norm1, corr_r, corr_i;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0, pend = 0;
  int age = 0, cyc = 0, acc_cyc = 0, n_res = 0;
  res_t nxt = '0, cur = '0;
  hqa_col_metric dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .col0_r(c0r), .col0_i(c0i), .col1_r(c1r), .col1_i(c1i),
    .norm0(norm0), .norm1(norm1), .corr_r(corr_r), .corr_i(corr_i),
    .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c, input logic [63:0] d);
    longint n0 = 0, n1 = 0, cr = 0, ci = 0;
    res_t r;
    for (int e = 0; e < 4; e++) begin
      longint xr0 = longint'($signed(a[63-16*e -: 16]));
      longint xi0 = longint'($signed(b[63-16*e -: 16]));
      longint xr1 = longint'($signed(c[63-16*e -: 16]));
      longint xi1 = longint'($signed(d[63-16*e -: 16]));
      n0 += xr0 * xr0 + xi0 * xi0;
      n1 += xr1 * xr1 + xi1 * xi1;
      cr += xr0 * xr1 + xi0 * xi1;
      ci += xr0 * xi1 - xi0 * xr1;
    end
    r.n0 = n0[35:0];
    r.n1 = n1[35:0];
    r.cr = cr[35:0];
    r.ci = ci[35:0];
    return r;
  endfunction
  // Transaction-level view: one pair in flight, result visible 4 edges after acceptance.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      pend = 0;
      cur = '0;
    end else if (pend && age >= 4) begin
      if (out_ready) begin
        pend = 0;
        n_res++;
      end
    end else if (pend) begin
      age++;
      if (age == 4) cur = nxt;
    end else if (in_valid) begin
      pend = 1;
      age = 0;
      acc_cyc = cyc;
      nxt = model(c0r, c0i, c1r, c1i);
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(!pend));
      chk("out_valid", 64'(out_valid), 64'(pend && age >= 4));
      chk("norm0", 64'(norm0[35:0]), 64'(cur.n0));
      chk("norm1", 64'(norm1[35:0]), 64'(cur.n1));
      chk("corr_r", 64'(corr_r[35:0]), 64'(cur.cr));
      chk("corr_i", 64'(corr_i[35:0]), 64'(cur.ci));
    end
  end
  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c, input logic [63:0] d);
    c0r = a; c0i = b; c1r = c; c1i = d;
    in_valid = 1;
    for (int i = 0; i < 20 && !pend; i++) @(negedge clk);
    chk("accepted", 64'(pend), 64'd1);
    in_valid = 0;
  endtask
  task automatic wait_ov();
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("out_valid_seen", 64'(out_valid), 64'd1);
    chk("latency", 64'(cyc - acc_cyc), 64'd4);
  endtask
  task automatic lit(input string nm, input logic [35:0] n0, input logic [35:0] n1, input logic [35:0] cr, input logic [35:0] ci);
    chk({nm, "_norm0"}, 64'(norm0[35:0]), 64'(n0));
    chk({nm, "_norm1"}, 64'(norm1[35:0]), 64'(n1));
    chk({nm, "_corr_r"}, 64'(corr_r[35:0]), 64'(cr));
    chk({nm, "_corr_i"}, 64'(corr_i[35:0]), 64'(ci));
  endtask
  task automatic take();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask
  function automatic logic [63:0] rword();
    logic [63:0] w;
    for (int e = 0; e < 4; e++) begin
      int sel = $urandom_range(0, 7);
      w[63-16*e -: 16] = (sel == 0) ? 16'h8000 : (sel == 1) ? 16'h7fff : 16'($urandom);
    end
    return w;
  endfunction
  localparam logic [63:0] ONES = 64'h0100_0100_0100_0100;
  localparam logic [63:0] E0 = 64'h0100_0000_0000_0000;
  localparam logic [63:0] MINW = 64'h8000_8000_8000_8000;
  initial begin
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    lit("reset", 36'h0, 36'h0, 36'h0, 36'h0);
    rst = 0;
    @(negedge clk);
    drive(ONES, '0, ONES, '0);
    wait_ov();
    lit("t1", 36'h4_0000, 36'h4_0000, 36'h4_0000, 36'h0);
    take();
    drive(E0, '0, '0, E0);
    wait_ov();
    lit("t2", 36'h1_0000, 36'h1_0000, 36'h0, 36'h1_0000);
    take();
    drive(MINW, MINW, MINW, MINW);
    wait_ov();
    lit("t3", 36'h2_0000_0000, 36'h2_0000_0000, 36'h2_0000_0000, 36'h0);
    c0r = ONES; c0i = E0; c1r = MINW; c1i = ONES;
    in_valid = 1;
    repeat (10) @(negedge clk);
    chk("held_in_ready", 64'(in_ready), 64'd0);
    lit("t4_frozen", 36'h2_0000_0000, 36'h2_0000_0000, 36'h2_0000_0000, 36'h0);
    take();
    chk("idle_after_done", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("accept_next", 64'(pend), 64'd1);
    in_valid = 0;
    wait_ov();
    take();
    drive(ONES, '0, ONES, '0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    lit("t5_reset", 36'h0, 36'h0, 36'h0, 36'h0);
    repeat (8) @(negedge clk);
    chk("t5_no_valid", 64'(out_valid), 64'd0);
    drive(ONES, '0, ONES, '0);
    wait_ov();
    lit("t5", 36'h4_0000, 36'h4_0000, 36'h4_0000, 36'h0);
    take();
    n_res = 0;
    for (int i = 0; i < 40000 && n_res < 1000; i++) begin
      c0r = rword(); c0i = rword(); c1r = rword(); c1i = rword();
      in_valid = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    chk("random_count", 64'(n_res >= 1000), 64'd1);
    in_valid = 0;
    out_ready = 1;
    repeat (8) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
